// File: rtl/weight_sram_port0_sched.sv
`default_nettype none
// ============================================================================
// Module   : weight_sram_port0_sched
// Purpose  : Schedules port 0 of the 4096x32b weight SRAM. The SRAM has a
//            1-cycle read latency and byte write enables. The port is shared
//            round-robin between a DMA weight-write stream and a PE
//            burst-read engine. Read data returns through a 2-entry output
//            buffer with valid/ready backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1            clock
//   rst         in   1            asynchronous reset, active-high
//   wr_valid    in   1            DMA write request
//   wr_ready    out  1            write accepted this cycle (combinational)
//   wr_addr     in   ADDR_W       write word address
//   wr_data     in   DATA_W       write data
//   wr_strb     in   4            byte strobes
//   rd_start    in   1            start read burst (ignored while rd_busy)
//   rd_base     in   ADDR_W       burst start address
//   rd_len      in   LEN_W        burst length in words (0 allowed)
//   rd_abort    in   1            kill burst, flush buffer
//   rd_busy     out  1            burst engine active
//   rd_done     out  1            1-cycle pulse, burst complete
//   rd_data     out  DATA_W       buffer head data
//   rd_valid    out  1            rd_data valid
//   rd_last     out  1            rd_data is the final beat of the burst
//   rd_ready    in   1            consumer accepts beat
//   sram_wea    out  4            SRAM port-0 byte write enables
//   sram_addr   out  SRAM_ADDR_W  SRAM port-0 address (upper bits zero)
//   sram_wdata  out  DATA_W       SRAM port-0 write data
//   sram_rdata  in   DATA_W       SRAM port-0 read data (cycle after issue)
// ============================================================================
module weight_sram_port0_sched #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 13,
   parameter int SRAM_ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   // DMA write stream
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic [3:0]             wr_strb,
   // PE burst-read engine control
   input  logic                   rd_start,
   input  logic [ADDR_W-1:0]      rd_base,
   input  logic [LEN_W-1:0]       rd_len,
   input  logic                   rd_abort,
   output logic                   rd_busy,
   output logic                   rd_done,
   // Read data stream
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   rd_last,
   input  logic                   rd_ready,
   // SRAM port 0
   output logic [3:0]             sram_wea,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   input  logic [DATA_W-1:0]      sram_rdata
);

   localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  c_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  c_LEN_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;          // next word to issue
   logic [LEN_W-1:0]    r_remaining;     // words still to issue
   logic                r_busy;
   logic                r_done;

   logic                r_inflight;      // a read was issued last cycle
   logic                r_inflight_last; // that read was the final issue

   logic [DATA_W-1:0]   r_buf_data [0:1];
   logic [1:0]          r_buf_last;
   logic                r_wptr;
   logic                r_rptr;
   logic [1:0]          r_count;

   logic                r_rr_read_last;  // read won the most recent contention
   logic [ADDR_W-1:0]   r_addr_hold;     // address presented last cycle

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic                w_pop;
   logic                w_head_last;
   logic [2:0]          w_credit;
   logic                w_rd_req;
   logic                w_contend;
   logic                w_wr_grant;
   logic                w_rd_grant;
   logic [ADDR_W-1:0]   w_port_addr;

   assign w_pop       = (r_count != 2'd0) && rd_ready;
   assign w_head_last = r_buf_last[r_rptr];

   // Occupancy the buffer will hold once the in-flight word lands and the
   // current pop retires. Issuing only while this is below 2 guarantees the
   // 2-entry buffer can never overflow, while still allowing one issue per
   // cycle when the consumer keeps up.
   assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   // An abort in the same cycle suppresses the issue so no stale capture
   // can land in the buffer after the flush.
   assign w_rd_req = (r_state == S_RUN) && (r_remaining != c_LEN_ZERO) &&
                     (w_credit < 3'd2) && !rd_abort;

   // Round-robin: on contention the side that lost the previous contention
   // wins; an uncontended requester is always granted.
   assign w_contend  = wr_valid && w_rd_req;
   assign w_wr_grant = wr_valid && (!w_rd_req || r_rr_read_last);
   assign w_rd_grant = w_rd_req && (!wr_valid || !r_rr_read_last);

   // Without a grant the address bus is held to avoid needless toggling.
   always_comb begin
      w_port_addr = r_addr_hold;
      if (w_wr_grant) begin
         w_port_addr = wr_addr;
      end else if (w_rd_grant) begin
         w_port_addr = r_addr;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign wr_ready   = w_wr_grant;
   assign sram_wea   = w_wr_grant ? wr_strb : 4'b0000;
   assign sram_wdata = w_wr_grant ? wr_data : '0;
   assign sram_addr  = {{(SRAM_ADDR_W-ADDR_W){1'b0}}, w_port_addr};

   assign rd_valid = (r_count != 2'd0);
   assign rd_data  = r_buf_data[r_rptr];
   assign rd_last  = rd_valid && w_head_last;
   assign rd_busy  = r_busy;
   assign rd_done  = r_done;

   // ------------------------------------------------------------------------
   // Burst engine FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (rd_abort) begin
         // Abort wins over everything, including a same-cycle rd_start.
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (rd_start) begin
                  r_addr      <= rd_base;
                  r_remaining <= rd_len;
                  r_busy      <= 1'b1;
                  if (rd_len == c_LEN_ZERO) begin
                     // Empty burst: report completion without any beats.
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_rd_grant) begin
                  // Address wraps naturally at the 4096-word boundary.
                  r_addr      <= r_addr + c_ADDR_ONE;
                  r_remaining <= r_remaining - c_LEN_ONE;
                  if (r_remaining == c_LEN_ONE) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_pop && w_head_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // In-flight tracking and 2-entry output buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_buf_data[0]   <= '0;
         r_buf_data[1]   <= '0;
         r_buf_last      <= 2'b00;
         r_wptr          <= 1'b0;
         r_rptr          <= 1'b0;
         r_count         <= 2'd0;
      end else if (rd_abort) begin
         // Flush: drop buffered beats and the pending capture.
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_buf_last      <= 2'b00;
         r_wptr          <= 1'b0;
         r_rptr          <= 1'b0;
         r_count         <= 2'd0;
      end else begin
         r_inflight      <= w_rd_grant;
         r_inflight_last <= (r_remaining == c_LEN_ONE);

         if (r_inflight) begin
            r_buf_data[r_wptr] <= sram_rdata;
            r_buf_last[r_wptr] <= r_inflight_last;
            r_wptr             <= ~r_wptr;
         end

         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end

         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   // ------------------------------------------------------------------------
   // Arbiter history and held address
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // "Read won last" so the first contention after reset goes to write.
         r_rr_read_last <= 1'b1;
         r_addr_hold    <= '0;
      end else begin
         if (w_contend) begin
            r_rr_read_last <= w_rd_grant;
         end
         r_addr_hold <= w_port_addr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_weight_sram_port0_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_sram_port0_sched
// Purpose  : Self-checking bench for weight_sram_port0_sched. A behavioural
//            SRAM with 1-cycle read latency sits on port 0; a shadow memory
//            tracks what the bench has written, and expected read beats are
//            queued when each burst is started and popped as beats retire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_sram_port0_sched;

   localparam int ADDR_W      = 12;
   localparam int DATA_W      = 32;
   localparam int LEN_W       = 13;
   localparam int SRAM_ADDR_W = 16;

   logic                   clk;
   logic                   rst;
   logic                   wr_valid;
   logic                   wr_ready;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic [3:0]             wr_strb;
   logic                   rd_start;
   logic [ADDR_W-1:0]      rd_base;
   logic [LEN_W-1:0]       rd_len;
   logic                   rd_abort;
   logic                   rd_busy;
   logic                   rd_done;
   logic [DATA_W-1:0]      rd_data;
   logic                   rd_valid;
   logic                   rd_last;
   logic                   rd_ready;
   logic [3:0]             sram_wea;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0]      sram_wdata;
   logic [DATA_W-1:0]      sram_rdata;

   weight_sram_port0_sched #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .LEN_W       (LEN_W),
      .SRAM_ADDR_W (SRAM_ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_strb    (wr_strb),
      .rd_start   (rd_start),
      .rd_base    (rd_base),
      .rd_len     (rd_len),
      .rd_abort   (rd_abort),
      .rd_busy    (rd_busy),
      .rd_done    (rd_done),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_last    (rd_last),
      .rd_ready   (rd_ready),
      .sram_wea   (sram_wea),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Behavioural SRAM: byte writes, registered read of the presented address
   // ------------------------------------------------------------------------
   logic [31:0] sram_mem [0:4095];
   logic [31:0] shadow   [0:4095];

   always @(posedge clk) begin : sram_model
      logic [31:0] w;
      w = sram_mem[sram_addr[11:0]];
      for (int b = 0; b < 4; b++) begin
         if (sram_wea[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
      end
      if (sram_wea != 4'b0000) sram_mem[sram_addr[11:0]] <= w;
      sram_rdata <= sram_mem[sram_addr[11:0]];
   end

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    pops  = 0;

   always @(negedge clk) begin : monitor
      beat_t e;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
         pops++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", rd_data, rd_last);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e.data || rd_last !== e.last) begin
               bad++;
               $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                        rd_data, rd_last, e.data, e.last);
            end
         end
      end
   end

   function automatic void apply_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   // All stimulus tasks start and end one time unit after a rising edge.
   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      n        = 0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_strb  = s;
      while (1) begin
         @(negedge clk);
         if (wr_ready === 1'b1) break;
         n++;
         if (n > 50) break;
      end
      total++;
      if (n > 50) begin
         bad++;
         $display("FAIL write_accept: got wr_ready=%b after 50 cycles, required 1", wr_ready);
      end else begin
         apply_write(a, d, s);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic start_burst(input logic [11:0] base, input logic [12:0] len);
      beat_t       b;
      logic [11:0] a;
      for (int k = 0; k < int'(len); k++) begin
         a      = base + 12'(k);
         b.data = shadow[a];
         b.last = (k == int'(len) - 1);
         exp_q.push_back(b);
      end
      rd_start = 1'b1;
      rd_base  = base;
      rd_len   = len;
      @(posedge clk); #1;
      rd_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((rd_busy !== 1'b0 || rd_valid !== 1'b0) && n <= 300) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n > 300) begin
         bad++;
         $display("FAIL %s_idle_timeout: got busy=%b valid=%b after 300 cycles, required idle", name, rd_busy, rd_valid);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_beats_missing: got %0d beats outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_pops(input int target, input string name);
      int n;
      n = 0;
      while (pops < target && n <= 100) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n > 100) begin
         bad++;
         $display("FAIL %s_pop_timeout: got %0d pops, required %0d", name, pops, target);
      end
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({rd_busy, rd_done, rd_valid, rd_last} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: got busy/done/valid/last=%b, required 0000", {rd_busy, rd_done, rd_valid, rd_last});
      end
      total++;
      if (rd_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_rd_data: got %h, required 00000000", rd_data);
      end
      total++;
      if (sram_wea !== 4'b0000) begin
         bad++;
         $display("FAIL reset_sram_wea: got %b, required 0000", sram_wea);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({rd_busy, rd_valid, wr_ready} !== 3'b000) begin
         bad++;
         $display("FAIL reset_release: got busy/valid/wr_ready=%b, required 000", {rd_busy, rd_valid, wr_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic_burst;
      logic [6:0] ev, el, ed;
      do_write(12'd5, 32'h11, 4'hF);
      do_write(12'd6, 32'h22, 4'hF);
      do_write(12'd7, 32'h33, 4'hF);
      rd_ready = 1'b1;
      ev = 7'b0011100;
      el = 7'b0010000;
      ed = 7'b0100000;
      start_burst(12'd5, 13'd3);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         total++;
         if ({rd_valid, rd_last, rd_done} !== {ev[c], el[c], ed[c]}) begin
            bad++;
            $display("FAIL basic_timing cycle %0d: got valid/last/done=%b, required %b",
                     c, {rd_valid, rd_last, rd_done}, {ev[c], el[c], ed[c]});
         end
      end
      @(posedge clk); #1;
      wait_idle("basic");
   endtask

   task automatic test_contention;
      int  widx;
      logic exp_w;
      for (int k = 0; k < 4; k++) do_write(12'(20 + k), 32'h2000 + k, 4'hF);
      rd_ready = 1'b1;
      start_burst(12'd20, 13'd4);
      widx     = 0;
      wr_valid = 1'b1;
      wr_addr  = 12'd100;
      wr_data  = 32'hA000;
      wr_strb  = 4'hF;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_w = (c % 2 == 0);
         total++;
         if (wr_ready !== exp_w) begin
            bad++;
            $display("FAIL rr_grant cycle %0d: got wr_ready=%b, required %b", c, wr_ready, exp_w);
         end
         if (wr_ready === 1'b1) begin
            apply_write(wr_addr, wr_data, wr_strb);
            widx++;
         end else begin
            total++;
            if (sram_addr !== 16'(20 + c / 2) || sram_wea !== 4'b0000) begin
               bad++;
               $display("FAIL rr_read_issue cycle %0d: got addr=%0d wea=%b, required addr=%0d wea=0000",
                        c, sram_addr, sram_wea, 20 + c / 2);
            end
         end
         @(posedge clk); #1;
         wr_addr = 12'(100 + widx);
         wr_data = 32'hA000 + widx;
      end
      wr_valid = 1'b0;
      wait_idle("contention");
      start_burst(12'd100, 13'd4);
      wait_idle("contention_readback");
   endtask

   task automatic test_backpressure;
      int          p0;
      logic [31:0] hd;
      logic        hl;
      for (int k = 0; k < 8; k++) do_write(12'(200 + k), 32'hB000_0000 + 32'(k * 7), 4'hF);
      rd_ready = 1'b1;
      p0 = pops;
      start_burst(12'd200, 13'd8);
      wait_pops(p0 + 2, "bp");
      rd_ready = 1'b0;
      hd = 32'h0;
      hl = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) begin
            hd = exp_q[0].data;
            hl = exp_q[0].last;
         end
         total++;
         if (rd_valid !== 1'b1 || rd_data !== hd || rd_last !== hl) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     c, rd_valid, rd_data, rd_last, hd, hl);
         end
      end
      @(posedge clk); #1;
      rd_ready = 1'b1;
      wait_idle("bp");
   endtask

   task automatic test_wrap;
      logic [15:0] ea [0:3];
      ea[0] = 16'd4094;
      ea[1] = 16'd4095;
      ea[2] = 16'd0;
      ea[3] = 16'd1;
      do_write(12'd4094, 32'hE0E0_0001, 4'hF);
      do_write(12'd4095, 32'hE0E0_0002, 4'hF);
      do_write(12'd0,    32'hE0E0_0003, 4'hF);
      do_write(12'd1,    32'hE0E0_0004, 4'hF);
      rd_ready = 1'b1;
      start_burst(12'd4094, 13'd4);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (sram_addr !== ea[c] || sram_wea !== 4'b0000) begin
            bad++;
            $display("FAIL wrap_addr issue %0d: got addr=%0d wea=%b, required addr=%0d wea=0000",
                     c, sram_addr, sram_wea, ea[c]);
         end
      end
      @(posedge clk); #1;
      wait_idle("wrap");
   endtask

   task automatic test_len0_and_busy;
      rd_ready = 1'b1;
      start_burst(12'd9, 13'd0);
      @(negedge clk);
      total++;
      if (rd_done !== 1'b1 || rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL len0_done: got done=%b valid=%b, required done=1 valid=0", rd_done, rd_valid);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (rd_done !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL len0_after cycle %0d: got done=%b valid=%b, required 0 0", c, rd_done, rd_valid);
         end
      end
      @(posedge clk); #1;
      start_burst(12'd5, 13'd3);
      // A second start while the engine runs must be ignored.
      rd_start = 1'b1;
      rd_base  = 12'd300;
      rd_len   = 13'd5;
      @(posedge clk); #1;
      rd_start = 1'b0;
      wait_idle("busy_ignore");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (rd_busy !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore cycle %0d: got busy=%b valid=%b, required 0 0", c, rd_busy, rd_valid);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_strobe_and_order;
      do_write(12'd50, 32'h1234_5678, 4'hF);
      do_write(12'd50, 32'hDEAD_BEEF, 4'h0);
      do_write(12'd50, 32'hAABB_CCDD, 4'b0101);
      rd_ready = 1'b1;
      start_burst(12'd50, 13'd1);
      wait_idle("strobe");
      // Write to 60 granted the cycle before the read of 60 issues.
      apply_write(12'd60, 32'hC0FF_EE00, 4'hF);
      exp_q.push_back({32'hC0FF_EE00, 1'b1});
      wr_valid = 1'b1;
      wr_addr  = 12'd60;
      wr_data  = 32'hC0FF_EE00;
      wr_strb  = 4'hF;
      rd_start = 1'b1;
      rd_base  = 12'd60;
      rd_len   = 13'd1;
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL order_write: got wr_ready=%b, required 1", wr_ready);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rd_start = 1'b0;
      wait_idle("order");
   endtask

   task automatic test_abort_and_rst;
      int p0;
      for (int k = 0; k < 10; k++) do_write(12'(400 + k), 32'h4000_0000 + 32'(k * 3), 4'hF);
      rd_ready = 1'b1;
      // Abort after beat 3.
      p0 = pops;
      start_burst(12'd400, 13'd10);
      wait_pops(p0 + 3, "abort");
      rd_abort = 1'b1;
      rd_ready = 1'b0;
      @(posedge clk); #1;
      rd_abort = 1'b0;
      rd_ready = 1'b1;
      exp_q.delete();
      total++;
      if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_flush: got valid=%b busy=%b, required 0 0", rd_valid, rd_busy);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (rd_done !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet cycle %0d: got done=%b valid=%b, required 0 0", c, rd_done, rd_valid);
         end
      end
      @(posedge clk); #1;
      start_burst(12'd5, 13'd3);
      wait_idle("abort_recover");
      // Asynchronous reset after beat 3.
      p0 = pops;
      start_burst(12'd400, 13'd10);
      wait_pops(p0 + 3, "rst");
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({rd_valid, rd_busy, rd_done} !== 3'b000) begin
         bad++;
         $display("FAIL rst_async: got valid/busy/done=%b, required 000", {rd_valid, rd_busy, rd_done});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (rd_done !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_quiet cycle %0d: got done=%b valid=%b, required 0 0", c, rd_done, rd_valid);
         end
      end
      @(posedge clk); #1;
      start_burst(12'd5, 13'd3);
      wait_idle("rst_recover");
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         sram_mem[i] = 32'h0;
         shadow[i]   = 32'h0;
      end
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_strb  = '0;
      rd_start = 1'b0;
      rd_base  = '0;
      rd_len   = '0;
      rd_abort = 1'b0;
      rd_ready = 1'b0;

      test_reset();
      test_basic_burst();
      test_contention();
      test_backpressure();
      test_wrap();
      test_len0_and_busy();
      test_strobe_and_order();
      test_abort_and_rst();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at 200000, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
